// File: rtl/design_b_pkg.sv
// Shared widths and types for the design_b registered priority encoder.
package design_b_pkg;

   localparam int DESIGN_B_IN_W  = 8;
   localparam int DESIGN_B_OUT_W = 3;

   typedef logic [DESIGN_B_IN_W-1:0]  req_t;
   typedef logic [DESIGN_B_OUT_W-1:0] idx_t;

endpackage

// File: rtl/design_b_prio_enc.sv
// Combinational core: index of the highest set request bit, plus any/multi flags.
// The multi-hot output exists only when DESIGN_B_ONEHOT_CHECK_EN is defined.
module design_b_prio_enc
   import design_b_pkg::*;
#(
   parameter int IN_W = DESIGN_B_IN_W,
   localparam int OUT_W = $clog2(IN_W)
) (
   input  logic [IN_W-1:0]  in,
   output logic [OUT_W-1:0] idx,
`ifdef DESIGN_B_ONEHOT_CHECK_EN
   output logic             multi,
`endif
   output logic             any
);

   // Ascending scan so the last (highest) set bit wins.
   always_comb begin
      idx = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (in[i]) begin
            idx = OUT_W'(i);
         end
      end
   end

   assign any = |in;

`ifdef DESIGN_B_ONEHOT_CHECK_EN
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi = |(in & (in - IN_W'(1)));
`endif

endmodule

// File: rtl/design_b.sv
// Registered 8-to-3 priority encoder with enable and async active-high reset.
// Define DESIGN_B_ONEHOT_CHECK_EN to register a multi-hot error flag on err.
module design_b
   import design_b_pkg::*;
#(
   parameter int IN_W = DESIGN_B_IN_W,
   localparam int OUT_W = $clog2(IN_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in,
   input  logic             en,
   output logic [OUT_W-1:0] out,
   output logic             out_valid,
   output logic             err
);

   logic [OUT_W-1:0] w_idx;
   logic             w_any;
   logic [OUT_W-1:0] r_out;
   logic             r_valid;

`ifdef DESIGN_B_ONEHOT_CHECK_EN
   logic             w_multi;
   logic             r_err;
`endif

   design_b_prio_enc #(.IN_W(IN_W)) u_enc (
      .in    (in),
      .idx   (w_idx),
`ifdef DESIGN_B_ONEHOT_CHECK_EN
      .multi (w_multi),
`endif
      .any   (w_any)
   );

   // Reset dominates; without en the outputs simply hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out   <= '0;
         r_valid <= 1'b0;
      end else if (en) begin
         r_out   <= w_idx;
         r_valid <= w_any;
      end
   end

`ifdef DESIGN_B_ONEHOT_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (en) begin
         r_err <= w_multi;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign out       = r_out;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_design_b.sv
// Self-checking bench for design_b against a log2/popcount reference model.
// Expected err tracks DESIGN_B_ONEHOT_CHECK_EN the same way the build does.
module tb_design_b;
   import design_b_pkg::*;

   logic       clk;
   logic       rst;
   req_t       reqIn;
   logic       enIn;
   logic [2:0] out;
   logic       outValid;
   logic       err;

   logic [2:0] expOut;
   logic       expValid;
   logic       expErr;

   int nCompared;
   int nMismatched;

   design_b dut (
      .clk       (clk),
      .rst       (rst),
      .in        (reqIn),
      .en        (enIn),
      .out       (out),
      .out_valid (outValid),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Highest set bit of a nonzero value is floor(log2(v)) = clog2(v+1)-1.
   function automatic logic [2:0] refIdx(input req_t v);
      if (v == '0) return 3'd0;
      return 3'($clog2(int'(v) + 1) - 1);
   endfunction

   function automatic logic refErr(input req_t v);
`ifdef DESIGN_B_ONEHOT_CHECK_EN
      return ($countones(v) > 1);
`else
      return 1'b0;
`endif
   endfunction

   task automatic modelClear();
      expOut   = 3'd0;
      expValid = 1'b0;
      expErr   = 1'b0;
   endtask

   // One clock: update the model from what was driven at the edge, then settle.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         modelClear();
      end else if (enIn) begin
         expOut   = refIdx(reqIn);
         expValid = (reqIn != '0);
         expErr   = refErr(reqIn);
      end
      #1;
   endtask

   task automatic test_reset();
      #1;
      rst   = 1'b1;
      enIn  = 1'b1;
      reqIn = 8'hFF;
      modelClear();
      #1;
      nCompared++;
      if ({out, outValid, err} !== 5'b000_0_0) begin
         nMismatched++;
         $display("[TB] FAIL reset_async: got out=%0d valid=%b err=%b, want 0/0/0", out, outValid, err);
      end
      step();
      nCompared++;
      if ({out, outValid, err} !== {expOut, expValid, expErr}) begin
         nMismatched++;
         $display("[TB] FAIL reset_held: got out=%0d valid=%b err=%b, want %0d/%b/%b", out, outValid, err, expOut, expValid, expErr);
      end
      rst = 1'b0;
      step();
      nCompared++;
      if ({out, outValid, err} !== {3'd7, 1'b1, refErr(8'hFF)}) begin
         nMismatched++;
         $display("[TB] FAIL reset_release: got out=%0d valid=%b err=%b, want 7/1/%b", out, outValid, err, refErr(8'hFF));
      end
   endtask

   task automatic test_onehot_sweep();
      enIn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         reqIn = req_t'(1) << i;
         step();
         nCompared++;
         if ({out, outValid, err} !== {3'(i), 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL onehot_%0d: got out=%0d valid=%b err=%b, want %0d/1/0", i, out, outValid, err, i);
         end
      end
   endtask

   task automatic test_priority();
      enIn  = 1'b1;
      reqIn = 8'b0010_0110;
      step();
      nCompared++;
      if ({out, outValid, err} !== {3'd5, 1'b1, refErr(8'b0010_0110)}) begin
         nMismatched++;
         $display("[TB] FAIL prio_26: got out=%0d valid=%b err=%b, want 5/1/%b", out, outValid, err, refErr(8'b0010_0110));
      end
      reqIn = 8'b1000_0001;
      step();
      nCompared++;
      if ({out, outValid, err} !== {3'd7, 1'b1, refErr(8'b1000_0001)}) begin
         nMismatched++;
         $display("[TB] FAIL prio_81: got out=%0d valid=%b err=%b, want 7/1/%b", out, outValid, err, refErr(8'b1000_0001));
      end
   endtask

   task automatic test_zero();
      enIn  = 1'b1;
      reqIn = 8'h00;
      step();
      nCompared++;
      if ({out, outValid, err} !== 5'b000_0_0) begin
         nMismatched++;
         $display("[TB] FAIL zero_in: got out=%0d valid=%b err=%b, want 0/0/0", out, outValid, err);
      end
   endtask

   task automatic test_enable_hold();
      enIn  = 1'b1;
      reqIn = 8'h10;
      step();
      nCompared++;
      if ({out, outValid} !== {3'd4, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL hold_capture: got out=%0d valid=%b, want 4/1", out, outValid);
      end
      enIn  = 1'b0;
      reqIn = 8'h02;
      for (int i = 0; i < 3; i++) begin
         step();
         nCompared++;
         if ({out, outValid, err} !== {3'd4, 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL hold_cycle%0d: got out=%0d valid=%b err=%b, want 4/1/0", i, out, outValid, err);
         end
      end
      enIn = 1'b1;
      step();
      nCompared++;
      if ({out, outValid} !== {3'd1, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL hold_resume: got out=%0d valid=%b, want 1/1", out, outValid);
      end
   endtask

   task automatic test_midstream_reset();
      enIn  = 1'b1;
      reqIn = 8'h40;
      step();
      nCompared++;
      if ({out, outValid} !== {3'd6, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL mid_pre: got out=%0d valid=%b, want 6/1", out, outValid);
      end
      #2;
      rst = 1'b1;
      modelClear();
      #1;
      nCompared++;
      if ({out, outValid, err} !== 5'b000_0_0) begin
         nMismatched++;
         $display("[TB] FAIL mid_async_clear: got out=%0d valid=%b err=%b, want 0/0/0", out, outValid, err);
      end
      #2;
      rst = 1'b0;
      step();
      nCompared++;
      if ({out, outValid, err} !== {3'd6, 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL mid_recover: got out=%0d valid=%b err=%b, want 6/1/0", out, outValid, err);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: reqIn = req_t'(1) << $urandom_range(0, 7);
            1: reqIn = 8'h00;
            default: reqIn = req_t'($urandom_range(0, 255));
         endcase
         enIn = ($urandom_range(0, 3) != 0);
         step();
         nCompared++;
         if ({out, outValid, err} !== {expOut, expValid, expErr}) begin
            nMismatched++;
            $display("[TB] FAIL random_%0d: in=%h en=%b got out=%0d valid=%b err=%b, want %0d/%b/%b",
                     n, reqIn, enIn, out, outValid, err, expOut, expValid, expErr);
         end
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst   = 1'b0;
      enIn  = 1'b0;
      reqIn = '0;
      modelClear();
      test_reset();
      test_onehot_sweep();
      test_priority();
      test_zero();
      test_enable_hold();
      test_midstream_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
